// File: rtl/fir_pkg.sv
// Shared definitions for the distributed-arithmetic FIR slice.
// Holds the default geometry (tap count, group size, coefficient and
// LUT-entry widths), the LUT address width seen by fir_filter, the build
// state encoding, and a helper that sizes the group-sum datapath.
package fir_pkg;

    localparam int NTAPS_DEF   = 64;
    localparam int GROUP_DEF   = 8;
    localparam int COEF_W_DEF  = 11;
    localparam int CIN_W_DEF   = 20;
    localparam int ADDR_W      = 11;
    localparam int COEF_ADDR_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUILD = 2'd1,
        ST_DONE  = 2'd2
    } build_state_t;

    // Bits needed to hold the signed sum of 'group' coefficients of
    // width 'coef_w' without overflow.
    function automatic int sum_width(input int coef_w, input int group);
        return coef_w + $clog2(group);
    endfunction

endpackage

// File: rtl/da_group_sum.sv
// da_group_sum: combinational masked signed adder for one DA group.
// Ports:
//   coefs : GROUP signed coefficients of the selected group
//   mask  : bit b set means coefs[b] contributes to the sum
//   sum   : signed sum of the selected coefficients (SUM_W bits, no overflow)
module da_group_sum
    import fir_pkg::*;
#(
    parameter int GROUP  = GROUP_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int SUM_W  = sum_width(COEF_W, GROUP)
) (
    input  logic [GROUP-1:0][COEF_W-1:0] coefs,
    input  logic [GROUP-1:0]             mask,
    output logic signed [SUM_W-1:0]      sum
);

    logic signed [SUM_W-1:0] acc_s;

    // Accumulate sign-extended coefficients whose mask bit is set; the
    // chain is flattened into an adder tree by synthesis.
    always_comb begin
        acc_s = '0;
        for (int b = 0; b < GROUP; b++) begin
            if (mask[b]) begin
                acc_s = acc_s + SUM_W'($signed(coefs[b]));
            end else begin
                acc_s = acc_s;
            end
        end
        sum = acc_s;
    end

endmodule

// File: rtl/da_lut_builder.sv
// da_lut_builder: builds the distributed-arithmetic LUT for fir_filter.
// A coefficient register file is written while idle. On start, every LUT
// entry (group k, pattern c) = sum of coef[k*GROUP+b] over set bits b of c
// is streamed out in ascending address order with a valid/ready handshake.
// Ports:
//   clk_fast  : single clock, rising edge
//   reset     : asynchronous active-high reset
//   coef_in   : signed coefficient write data
//   coef_addr : coefficient index
//   coef_we   : coefficient write strobe (honoured only when idle)
//   start     : single-cycle build request
//   CIN       : sign-extended LUT entry (0 when not valid)
//   CADDR     : LUT address (0 when not valid)
//   CLOAD     : high for the whole build
//   cin_valid : CIN/CADDR hold a valid entry
//   cin_ready : downstream accepts the entry when valid && ready
//   busy      : high while building
//   done      : one-cycle pulse after the last entry is accepted
module da_lut_builder
    import fir_pkg::*;
#(
    parameter int NTAPS  = NTAPS_DEF,
    parameter int GROUP  = GROUP_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int CIN_W  = CIN_W_DEF
) (
    input  logic                     clk_fast,
    input  logic                     reset,
    input  logic signed [COEF_W-1:0] coef_in,
    input  logic [COEF_ADDR_W-1:0]   coef_addr,
    input  logic                     coef_we,
    input  logic                     start,
    output logic signed [CIN_W-1:0]  CIN,
    output logic [ADDR_W-1:0]        CADDR,
    output logic                     CLOAD,
    output logic                     cin_valid,
    input  logic                     cin_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int SUM_W       = sum_width(COEF_W, GROUP);
    localparam int IDX_W       = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int NUM_ENTRIES = (NTAPS / GROUP) * (2 ** GROUP);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);

    build_state_t             state_r;
    logic signed [COEF_W-1:0] coef_r [NTAPS];

    logic [ADDR_W-1:0]             next_addr_s;
    logic [ADDR_W-GROUP-1:0]       grp_s;
    logic [GROUP-1:0]              mask_s;
    logic [GROUP-1:0][COEF_W-1:0]  grp_coefs_s;
    logic signed [SUM_W-1:0]       sum_s;

    // Address of the entry that the next register update will present:
    // entry 0 on the start edge, the successor of CADDR on each acceptance.
    always_comb begin
        case (state_r)
            ST_IDLE:  next_addr_s = '0;
            ST_BUILD: next_addr_s = CADDR + 11'd1;
            ST_DONE:  next_addr_s = '0;
            default:  next_addr_s = '0;
        endcase
    end

    assign grp_s  = next_addr_s[ADDR_W-1:GROUP];
    assign mask_s = next_addr_s[GROUP-1:0];

    // Gather the GROUP coefficients belonging to the addressed group.
    always_comb begin
        for (int b = 0; b < GROUP; b++) begin
            grp_coefs_s[b] = coef_r[IDX_W'(int'(grp_s) * GROUP + b)];
        end
    end

    da_group_sum #(
        .GROUP  (GROUP),
        .COEF_W (COEF_W),
        .SUM_W  (SUM_W)
    ) u_group_sum (
        .coefs (grp_coefs_s),
        .mask  (mask_s),
        .sum   (sum_s)
    );

    // Coefficient register file; writes are accepted only while idle so a
    // build always sees a stable table.
    always_ff @(posedge clk_fast or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NTAPS; n++) begin
                coef_r[n] <= '0;
            end
        end else if (coef_we && (state_r == ST_IDLE) && (int'(coef_addr) < NTAPS)) begin
            coef_r[IDX_W'(coef_addr)] <= coef_in;
        end
    end

    // Build sequencer with registered outputs. A coefficient write in the
    // same cycle as start lands before entry 1 is computed, and entry 0 is
    // always zero, so the build sees the new value.
    always_ff @(posedge clk_fast or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            CIN       <= '0;
            CADDR     <= '0;
            CLOAD     <= 1'b0;
            cin_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r   <= ST_BUILD;
                        CIN       <= CIN_W'(sum_s);
                        CADDR     <= '0;
                        CLOAD     <= 1'b1;
                        cin_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_BUILD: begin
                    if (cin_ready) begin
                        if (CADDR == LAST_ADDR) begin
                            state_r   <= ST_DONE;
                            CIN       <= '0;
                            CADDR     <= '0;
                            CLOAD     <= 1'b0;
                            cin_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            CIN   <= CIN_W'(sum_s);
                            CADDR <= next_addr_s;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    CIN       <= '0;
                    CADDR     <= '0;
                    CLOAD     <= 1'b0;
                    cin_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_da_lut_builder.sv
// Self-checking bench for da_lut_builder: table of {pattern, address,
// expected entry} records plus directed multi-cycle sequences for stall,
// reset abort, write/start during build and write together with start.
module tb_da_lut_builder;

    logic        clk_fast = 1'b0;
    logic        reset;
    logic [10:0] coef_in;
    logic [5:0]  coef_addr;
    logic        coef_we;
    logic        start;
    logic [19:0] CIN;
    logic [10:0] CADDR;
    logic        CLOAD;
    logic        cin_valid;
    logic        cin_ready;
    logic        busy;
    logic        done;

    da_lut_builder dut (
        .clk_fast  (clk_fast),
        .reset     (reset),
        .coef_in   (coef_in),
        .coef_addr (coef_addr),
        .coef_we   (coef_we),
        .start     (start),
        .CIN       (CIN),
        .CADDR     (CADDR),
        .CLOAD     (CLOAD),
        .cin_valid (cin_valid),
        .cin_ready (cin_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_fast = ~clk_fast;

    typedef struct {
        int          pat;
        int          addr;
        logic [19:0] exp;
    } vec_t;

    vec_t        vecs [16];
    logic [19:0] cap_cin [2048];
    int n_checks = 0;
    int n_fail   = 0;
    int n_acc, n_done, seq_err, stall_err, stall_cycles, first_valid_cyc, done_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] pat_coef(input int pat, input int n);
        int v;
        case (pat)
            1:       v = n + 1;
            2:       v = -512;
            3:       v = 512;
            default: v = 0;
        endcase
        return 11'(v);
    endfunction

    task automatic load_coefs(input int pat);
        for (int n = 0; n < 64; n++) begin
            coef_we   = 1'b1;
            coef_addr = 6'(n);
            coef_in   = pat_coef(pat, n);
            @(posedge clk_fast); #1;
        end
        coef_we = 1'b0;
    endtask

    // Start a build and drive ready per cycle, recording accepted entries.
    task automatic run_build(input int stall_addr, input int stall_len,
                             input int inject_addr, input bit we_with_start);
        int cyc, stall_cnt, post;
        bit done_seen;
        logic [19:0] held_cin;
        logic [10:0] held_addr;
        n_acc = 0; n_done = 0; seq_err = 0; stall_err = 0; stall_cycles = 0;
        first_valid_cyc = -1; done_cyc = -1;
        held_cin = '0; held_addr = '0;
        start = 1'b1;
        if (we_with_start) begin
            coef_we = 1'b1; coef_addr = 6'd1; coef_in = 11'd100;
        end
        @(posedge clk_fast); #1;
        start = 1'b0; coef_we = 1'b0;
        cyc = 1; stall_cnt = 0; post = 0; done_seen = 1'b0;
        while (cyc < 3000 && post < 4) begin
            cin_ready = 1'b1; coef_we = 1'b0; start = 1'b0;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
                done_seen = 1'b1;
            end
            if (done_seen) post++;
            if (cin_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (CLOAD !== 1'b1 || busy !== 1'b1 || done !== 1'b0) seq_err++;
                if (int'(CADDR) == stall_addr && stall_cnt < stall_len) begin
                    if (stall_cnt == 0) begin
                        held_cin = CIN; held_addr = CADDR;
                    end else if (CIN !== held_cin || CADDR !== held_addr) begin
                        stall_err++;
                    end
                    stall_cnt++; stall_cycles++;
                    cin_ready = 1'b0;
                end else begin
                    if (int'(CADDR) != n_acc) seq_err++;
                    if (n_acc < 2048) cap_cin[n_acc] = CIN;
                    n_acc++;
                end
                if (int'(CADDR) == inject_addr) begin
                    coef_we = 1'b1; coef_addr = 6'd0; coef_in = 11'd7; start = 1'b1;
                end
            end else begin
                if (CIN !== 20'd0 || CADDR !== 11'd0 || CLOAD !== 1'b0 || busy !== 1'b0) seq_err++;
            end
            @(posedge clk_fast); #1;
            cyc++;
        end
        cin_ready = 1'b1; coef_we = 1'b0; start = 1'b0;
    endtask

    initial begin
        int cnt;
        bit seen_done;

        vecs[0]  = '{0, 0,    20'h00000};
        vecs[1]  = '{0, 1,    20'h00000};
        vecs[2]  = '{0, 2047, 20'h00000};
        vecs[3]  = '{1, 1,    20'h00001};
        vecs[4]  = '{1, 3,    20'h00003};
        vecs[5]  = '{1, 128,  20'h00008};
        vecs[6]  = '{1, 255,  20'h00024};
        vecs[7]  = '{1, 257,  20'h00009};
        vecs[8]  = '{1, 1029, 20'h00044};
        vecs[9]  = '{1, 2047, 20'h001E4};
        vecs[10] = '{2, 1,    20'hFFE00};
        vecs[11] = '{2, 255,  20'hFF000};
        vecs[12] = '{2, 2047, 20'hFF000};
        vecs[13] = '{3, 6,    20'h00400};
        vecs[14] = '{3, 255,  20'h01000};
        vecs[15] = '{3, 1024, 20'h00000};

        reset = 1'b1; coef_in = '0; coef_addr = '0; coef_we = 1'b0;
        start = 1'b0; cin_ready = 1'b1;
        #3;
        check("reset_outputs", {12'd0, CIN, CADDR, CLOAD, cin_valid, busy, done}, 32'd0);
        repeat (3) @(posedge clk_fast);
        #1; reset = 1'b0;
        @(posedge clk_fast); #1;
        check("idle_outputs", {12'd0, CIN, CADDR, CLOAD, cin_valid, busy, done}, 32'd0);

        // One full build per coefficient pattern; pattern 1 stalls at address 10.
        for (int pat = 0; pat < 4; pat++) begin
            if (pat != 0) load_coefs(pat);
            if (pat == 1) run_build(10, 5, -1, 1'b0);
            else          run_build(-1, 0, -1, 1'b0);
            check($sformatf("p%0d_first_valid", pat), first_valid_cyc, 1);
            check($sformatf("p%0d_accepted", pat), n_acc, 2048);
            check($sformatf("p%0d_sequence", pat), seq_err, 0);
            check($sformatf("p%0d_done_count", pat), n_done, 1);
            check($sformatf("p%0d_done_cycle", pat), done_cyc, (pat == 1) ? 2054 : 2049);
            if (pat == 1) begin
                check("stall_hold", stall_err, 0);
                check("stall_cycles", stall_cycles, 5);
            end
            for (int i = 0; i < 16; i++) begin
                if (vecs[i].pat == pat) begin
                    check($sformatf("p%0d_cin_addr%0d", pat, vecs[i].addr),
                          {12'd0, cap_cin[vecs[i].addr]}, {12'd0, vecs[i].exp});
                end
            end
        end

        // Write and start during a build must be ignored.
        load_coefs(1);
        run_build(-1, 0, 0, 1'b0);
        check("inject_addr1", {12'd0, cap_cin[1]}, 32'd1);
        check("inject_addr3", {12'd0, cap_cin[3]}, 32'd3);
        check("inject_done_count", n_done, 1);
        check("inject_accepted", n_acc, 2048);

        // Write together with start in idle: the build uses the new value.
        run_build(-1, 0, -1, 1'b1);
        check("we_start_addr2", {12'd0, cap_cin[2]}, 32'd100);
        check("we_start_addr3", {12'd0, cap_cin[3]}, 32'd101);
        check("we_start_done_count", n_done, 1);

        // Reset in the middle of a build.
        start = 1'b1; cin_ready = 1'b1;
        @(posedge clk_fast); #1;
        start = 1'b0;
        cnt = 0;
        while (!(cin_valid && CADDR == 11'd100) && cnt < 500) begin
            @(posedge clk_fast); #1;
            cnt++;
        end
        check("abort_reached_addr100", {21'd0, CADDR}, 32'd100);
        #1; reset = 1'b1; #1;
        check("abort_async_outputs", {12'd0, CIN, CADDR, CLOAD, cin_valid, busy, done}, 32'd0);
        @(posedge clk_fast); #1;
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (10) begin
            @(posedge clk_fast); #1;
            if (done || cin_valid || busy || CLOAD) seen_done = 1'b1;
        end
        check("abort_stays_idle", {31'd0, seen_done}, 32'd0);
        run_build(-1, 0, -1, 1'b0);
        check("restart_first_valid", first_valid_cyc, 1);
        check("restart_accepted", n_acc, 2048);
        check("restart_sequence", seq_err, 0);
        check("restart_coef_cleared_addr3", {12'd0, cap_cin[3]}, 32'd0);
        check("restart_coef_cleared_addr2047", {12'd0, cap_cin[2047]}, 32'd0);
        check("restart_done_count", n_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
